// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks.
// Holds the controller state encoding, register-index width and the NOP word.
package pipeline_pkg;

  localparam int REG_W = 4;

  // Instruction word a flushed pipeline register loads.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Write-enable / flush controls for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_we;
    logic fd_en;
    logic fd_fl;
    logic de_en;
    logic de_fl;
    logic em_en;
    logic mw_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '{pc_we: 1'b0, fd_en: 1'b0, fd_fl: 1'b0, de_en: 1'b0,
                                    de_fl: 1'b0, em_en: 1'b0, mw_en: 1'b0};
  localparam ctrl_t CTRL_ADVANCE = '{pc_we: 1'b1, fd_en: 1'b1, fd_fl: 1'b0, de_en: 1'b1,
                                     de_fl: 1'b0, em_en: 1'b1, mw_en: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the D instruction reads a register that the load in X
// has not yet produced. Register 0 is hardwired and never hazards.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rs_d,
  input  logic             uses_rt_d,
  input  logic             mem_read_x,
  input  logic [REG_W-1:0] rd_x,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = uses_rs_d && (rs_d == rd_x);
    rt_match = uses_rt_d && (rt_d == rd_x);
    load_use = mem_read_x && (rd_x != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the F/D/X/M/W pipeline: load-use bubbles, branch
// squashes, memory wait states and HLT draining, plus a saturating stall counter.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rs_d,
  input  logic             uses_rt_d,
  input  logic             mem_read_x,
  input  logic [REG_W-1:0] rd_x,
  input  logic             branch_taken_d,
  input  logic             halt_d,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_write_en,
  output logic             fd_enable,
  output logic             fd_flush,
  output logic             de_enable,
  output logic             de_flush,
  output logic             em_enable,
  output logic             mw_enable,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0]       DRAIN_INIT = 2'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use;
  ctrl_t            ctrl;

  hazard_detect u_hazard_detect (
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .uses_rs_d  (uses_rs_d),
    .uses_rt_d  (uses_rt_d),
    .mem_read_x (mem_read_x),
    .rd_x       (rd_x),
    .load_use   (load_use)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      drain_q       <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_RUN: begin
        // HLT is only accepted when nothing of higher priority claims the cycle.
        if (!dmem_stall && !load_use && !branch_taken_d && halt_d) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (!dmem_stall) begin
          drain_d = drain_q - 2'd1;
          if (drain_q == 2'd1) state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    ctrl = CTRL_ADVANCE;
    unique case (state_q)
      ST_RUN: begin
        if (dmem_stall) begin
          ctrl = CTRL_IDLE;
        end else if (load_use) begin
          ctrl.pc_we = 1'b0;
          ctrl.fd_en = 1'b0;
          ctrl.de_fl = 1'b1;
        end else if (branch_taken_d) begin
          ctrl.fd_fl = 1'b1;
        end else if (halt_d || imem_stall) begin
          ctrl.pc_we = 1'b0;
          ctrl.fd_fl = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dmem_stall) begin
          ctrl = CTRL_IDLE;
        end else begin
          ctrl.pc_we = 1'b0;
          ctrl.fd_fl = 1'b1;
          ctrl.de_fl = 1'b1;
        end
      end
      default: ctrl = CTRL_IDLE;
    endcase
    if (!rst) ctrl = CTRL_IDLE;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (state_q == ST_RUN && !ctrl.pc_we && stall_count_q != CNT_MAX)
      stall_count_d = stall_count_q + 1'b1;
  end

  assign pc_write_en = ctrl.pc_we;
  assign fd_enable   = ctrl.fd_en;
  assign fd_flush    = ctrl.fd_fl;
  assign de_enable   = ctrl.de_en;
  assign de_flush    = ctrl.de_fl;
  assign em_enable   = ctrl.em_en;
  assign mw_enable   = ctrl.mw_en;
  assign halted      = rst && (state_q == ST_HALTED);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a 4-bit stall counter.
// Control outputs are viewed as {pc_we, fd_en, fd_fl, de_en, de_fl, em_en, mw_en}.
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 4;

  localparam logic [6:0] C_ZERO   = 7'b0000000;
  localparam logic [6:0] C_RUN    = 7'b1101011;
  localparam logic [6:0] C_LU     = 7'b0001111;
  localparam logic [6:0] C_BR     = 7'b1111011;
  localparam logic [6:0] C_BUBBLE = 7'b0111011;
  localparam logic [6:0] C_DRAIN  = 7'b0111111;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       rs_d, rt_d, rd_x;
  logic             uses_rs_d, uses_rt_d, mem_read_x;
  logic             branch_taken_d, halt_d, imem_stall, dmem_stall;
  logic             pc_write_en, fd_enable, fd_flush, de_enable, de_flush;
  logic             em_enable, mw_enable, halted;
  logic [CNT_W-1:0] stall_count;
  logic [6:0]       ctrl_v;
  logic [4:0]       en_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .uses_rs_d      (uses_rs_d),
    .uses_rt_d      (uses_rt_d),
    .mem_read_x     (mem_read_x),
    .rd_x           (rd_x),
    .branch_taken_d (branch_taken_d),
    .halt_d         (halt_d),
    .imem_stall     (imem_stall),
    .dmem_stall     (dmem_stall),
    .pc_write_en    (pc_write_en),
    .fd_enable      (fd_enable),
    .fd_flush       (fd_flush),
    .de_enable      (de_enable),
    .de_flush       (de_flush),
    .em_enable      (em_enable),
    .mw_enable      (mw_enable),
    .halted         (halted),
    .stall_count    (stall_count)
  );

  assign ctrl_v = {pc_write_en, fd_enable, fd_flush, de_enable, de_flush, em_enable, mw_enable};
  assign en_v   = {pc_write_en, fd_enable, de_enable, em_enable, mw_enable};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 4'd0; rt_d = 4'd0; rd_x = 4'd0;
    uses_rs_d = 1'b0; uses_rt_d = 1'b0; mem_read_x = 1'b0;
    branch_taken_d = 1'b0; halt_d = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  task automatic set_load_use();
    mem_read_x = 1'b1; rd_x = 4'd5; rs_d = 4'd5; uses_rs_d = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("reset_ctrl", 32'(ctrl_v), 32'(C_ZERO));
    chk("reset_halted", 32'(halted), 32'd0);
    tick();
    chk("reset_count", 32'(stall_count), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) tick();
    chk("idle_ctrl", 32'(ctrl_v), 32'(C_RUN));
    chk("idle_halted", 32'(halted), 32'd0);
    chk("idle_count", 32'(stall_count), 32'd0);

    set_load_use(); #1;
    chk("lu_ctrl", 32'(ctrl_v), 32'(C_LU));
    tick();
    chk("lu_count", 32'(stall_count), 32'd1);

    rd_x = 4'd0; rs_d = 4'd0; #1;
    chk("r0_ctrl", 32'(ctrl_v), 32'(C_RUN));
    tick();
    chk("r0_count", 32'(stall_count), 32'd1);

    // Rt match path, with a taken branch that must be ignored.
    clear_inputs();
    mem_read_x = 1'b1; rd_x = 4'd9; rt_d = 4'd9; uses_rt_d = 1'b1; rs_d = 4'd9;
    branch_taken_d = 1'b1; #1;
    chk("lu_br_ctrl", 32'(ctrl_v), 32'(C_LU));
    tick();
    chk("lu_br_count", 32'(stall_count), 32'd2);

    clear_inputs();
    mem_read_x = 1'b1; rd_x = 4'd9; rs_d = 4'd9; uses_rs_d = 1'b0; #1;
    chk("no_use_ctrl", 32'(ctrl_v), 32'(C_RUN));

    clear_inputs();
    branch_taken_d = 1'b1; imem_stall = 1'b1; #1;
    chk("br_imem_ctrl", 32'(ctrl_v), 32'(C_BR));
    tick();
    chk("br_imem_count", 32'(stall_count), 32'd2);

    clear_inputs();
    set_load_use(); dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dmem_freeze_ctrl", 32'(ctrl_v), 32'(C_ZERO));
      tick();
    end
    chk("dmem_freeze_count", 32'(stall_count), 32'd6);
    dmem_stall = 1'b0; #1;
    chk("dmem_then_lu_ctrl", 32'(ctrl_v), 32'(C_LU));
    tick();
    chk("dmem_then_lu_count", 32'(stall_count), 32'd7);

    clear_inputs();
    imem_stall = 1'b1; #1;
    chk("imem_ctrl", 32'(ctrl_v), 32'(C_BUBBLE));
    tick();
    chk("imem_count", 32'(stall_count), 32'd8);

    clear_inputs();
    halt_d = 1'b1; #1;
    chk("halt_ctrl", 32'(ctrl_v), 32'(C_BUBBLE));
    tick();
    halt_d = 1'b0;
    chk("halt_count", 32'(stall_count), 32'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_ctrl", 32'(ctrl_v), 32'(C_DRAIN));
      chk("drain_halted", 32'(halted), 32'd0);
      tick();
    end
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_ctrl", 32'(ctrl_v), 32'(C_ZERO));
    imem_stall = 1'b1; branch_taken_d = 1'b1;
    tick();
    chk("halted_sticky", 32'(halted), 32'd1);
    chk("halted_count_frozen", 32'(stall_count), 32'd9);
    clear_inputs();

    rst = 1'b0; #1;
    chk("rst_in_halt_ctrl", 32'(ctrl_v), 32'(C_ZERO));
    chk("rst_in_halt_halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b1; #1;
    chk("post_rst_count", 32'(stall_count), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_ctrl", 32'(ctrl_v), 32'(C_RUN));

    // HLT again with a 2-cycle data-memory wait inside the drain.
    halt_d = 1'b1; tick(); halt_d = 1'b0;
    #1; chk("drain2_c1", 32'(ctrl_v), 32'(C_DRAIN));
    tick();
    dmem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drain2_freeze_en", 32'(en_v), 32'd0);
      chk("drain2_freeze_halted", 32'(halted), 32'd0);
      tick();
    end
    dmem_stall = 1'b0;
    #1; chk("drain2_c2", 32'(ctrl_v), 32'(C_DRAIN));
    tick();
    #1; chk("drain2_c3", 32'(ctrl_v), 32'(C_DRAIN));
    chk("drain2_not_yet", 32'(halted), 32'd0);
    tick();
    chk("drain2_halted", 32'(halted), 32'd1);
    chk("drain2_count", 32'(stall_count), 32'd1);

    rst = 1'b0; tick(); rst = 1'b1;
    imem_stall = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(stall_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_15", 32'(stall_count), 32'd15);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
